debug_terminal_scanner: RTL



---
 rtl/debug_terminal_scanner.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/debug_terminal_scanner.sv
// debug_terminal_scanner
//   Scans a COLUMNS x ROWS character terminal one cell per accepted write.
//   A cell shows either a hex digit of a watched channel (taken from a
//   per-frame snapshot) or the background character from an external ROM.
//   The snapshot is refreshed at each frame wrap unless freeze is high, and
//   digits of channels that changed since the previous frame can carry bit 7.
// Ports:
//   clock, reset          sole clock (rising edge), synchronous active-high reset
//   channelData           CHANNELS packed WIDTH-bit watched values
//   freeze                hold the current snapshot across the frame wrap
//   backgroundAddress     scan counter, drives the async background ROM
//   backgroundCharacter   ROM data for backgroundAddress
//   terminalAddress       registered write address
//   terminalWriteData     registered write character
//   shouldWriteTerminal   registered write valid
//   terminalReady         sink accepts when valid && ready
//   frameDone             one-cycle pulse after the last cell is accepted
//   frameCount            completed frames, wraps
module debug_terminal_scanner #(
    parameter int COLUMNS      = 80,
    parameter int ROWS         = 30,
    parameter int ADDRESS_BITS = 12,
    parameter int CHANNELS     = 8,
    parameter int WIDTH        = 32,
    parameter int FIELD_BASE   = 0,
    parameter int FIELD_STRIDE = 80,
    parameter int HIGHLIGHT    = 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [CHANNELS*WIDTH-1:0] channelData,
    input  logic                      freeze,
    output logic [ADDRESS_BITS-1:0]   backgroundAddress,
    input  logic [7:0]                backgroundCharacter,
    output logic [ADDRESS_BITS-1:0]   terminalAddress,
    output logic [7:0]                terminalWriteData,
    output logic                      shouldWriteTerminal,
    input  logic                      terminalReady,
    output logic                      frameDone,
    output logic [15:0]               frameCount
);

    localparam int DIGITS = WIDTH / 4;
    localparam int CELLS  = COLUMNS * ROWS;
    localparam logic [ADDRESS_BITS-1:0] LAST_ADDR = ADDRESS_BITS'(CELLS - 1);

    typedef enum logic {PRIME, SCAN} state_t;

    state_t state_q, state_d;

    logic [ADDRESS_BITS-1:0]   counter_q, counter_d;
    logic [ADDRESS_BITS-1:0]   addr_q, addr_d;
    logic [7:0]                data_q, data_d;
    logic                      valid_q, valid_d;
    logic                      done_q, done_d;
    logic [15:0]               count_q, count_d;
    logic [CHANNELS*WIDTH-1:0] snap_q, snap_d;
    logic [CHANNELS*WIDTH-1:0] prev_q, prev_d;

    logic load, wrap, capture, accept_last;

    // State register
    always_ff @(posedge clock) begin
        if (reset) state_q <= PRIME;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            PRIME:   state_d = SCAN;
            SCAN:    state_d = SCAN;
            default: state_d = PRIME;
        endcase
    end

    // FSM outputs
    always_comb begin
        capture = (state_q == PRIME);
        load    = (state_q == SCAN) && (!valid_q || terminalReady);
        wrap    = load && (counter_q == LAST_ADDR);
    end

    // Cell character for the current scan address; lowest channel wins on overlap.
    logic [31:0]      scan_addr, field_base, digit_idx, shamt;
    logic [WIDTH-1:0] chan_val, chan_shift;
    logic [3:0]       nibble;
    logic             found;
    logic [7:0]       cell_char;

    always_comb begin
        scan_addr  = 32'(counter_q);
        cell_char  = backgroundCharacter;
        found      = 1'b0;
        field_base = '0;
        digit_idx  = '0;
        shamt      = '0;
        chan_val   = '0;
        chan_shift = '0;
        nibble     = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            field_base = 32'(FIELD_BASE) + 32'(c) * 32'(FIELD_STRIDE);
            if (!found && scan_addr >= field_base && scan_addr < field_base + 32'(DIGITS)) begin
                found      = 1'b1;
                digit_idx  = scan_addr - field_base;
                shamt      = 32'(WIDTH - 4) - 32'd4 * digit_idx;
                chan_val   = snap_q[c*WIDTH +: WIDTH];
                chan_shift = chan_val >> shamt;
                nibble     = chan_shift[3:0];
                cell_char  = {4'h0, nibble} + ((nibble < 4'd10) ? 8'h30 : 8'h37);
                if (HIGHLIGHT != 0 && chan_val != prev_q[c*WIDTH +: WIDTH])
                    cell_char = cell_char | 8'h80;
            end
        end
    end

    // Datapath next state
    always_comb begin
        counter_d   = counter_q;
        addr_d      = addr_q;
        data_d      = data_q;
        valid_d     = valid_q;
        snap_d      = snap_q;
        prev_d      = prev_q;
        accept_last = valid_q && terminalReady && (addr_q == LAST_ADDR);
        done_d      = accept_last;
        count_d     = accept_last ? count_q + 16'd1 : count_q;
        if (capture) snap_d = channelData;
        if (load) begin
            addr_d    = counter_q;
            data_d    = cell_char;
            valid_d   = 1'b1;
            counter_d = wrap ? '0 : counter_q + 1'b1;
        end
        // The last cell already latched the old snapshot, so swapping here
        // makes address 0 of the next frame the first user of the new one.
        if (wrap && !freeze) begin
            prev_d = snap_q;
            snap_d = channelData;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            counter_q <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            count_q   <= '0;
            snap_q    <= '0;
            prev_q    <= '0;
        end else begin
            counter_q <= counter_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
            count_q   <= count_d;
            snap_q    <= snap_d;
            prev_q    <= prev_d;
        end
    end

    assign backgroundAddress   = counter_q;
    assign terminalAddress     = addr_q;
    assign terminalWriteData   = data_q;
    assign shouldWriteTerminal = valid_q;
    assign frameDone           = done_q;
    assign frameCount          = count_q;

endmodule
